// File: rtl/fp_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_norm_pipe
// Brief    : Two-stage post-add normaliser (LZC shift, carry, ovf/unf/zero)
//            with valid/ready handshakes. Optional FP_NORM_EVENT_CNT_EN adds
//            saturating overflow/underflow event counters.
// Revision : 1.0
// ============================================================================
module fp_norm_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int LZC_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [MANT_W:0]   in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_zero
`ifdef FP_NORM_EVENT_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [15:0]       ovf_cnt,
  output logic [15:0]       unf_cnt
`endif
);

  localparam int              CMP_W       = ((EXP_W > LZC_W) ? EXP_W : LZC_W) + 1;
  localparam logic [EXP_W-1:0] c_exp_max  = '1;
  localparam logic [EXP_W-1:0] c_exp_sat  = {{(EXP_W-1){1'b1}}, 1'b0};

  logic              w_adv;
  logic [LZC_W-1:0]  w_lzc;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic [MANT_W:0]   r_s1_mant;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [LZC_W-1:0]  r_s1_lzc;

  logic [MANT_W-1:0] w_frac;
  logic [MANT_W-1:0] w_mant;
  logic [EXP_W-1:0]  w_exp;
  logic              w_ovf;
  logic              w_unf;
  logic              w_zero;

  logic              r_s2_valid;
  logic              r_out_sign;
  logic [MANT_W-1:0] r_out_mant;
  logic [EXP_W-1:0]  r_out_exp;
  logic              r_out_ovf;
  logic              r_out_unf;
  logic              r_out_zero;

  assign w_adv    = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_adv;

  // Highest set bit wins, so the last assignment in the ascending loop is the LZC.
  always_comb begin
    w_lzc = LZC_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (in_mant[i]) w_lzc = LZC_W'(MANT_W - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mant  <= '0;
      r_s1_exp   <= '0;
      r_s1_lzc   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_sign;
        r_s1_mant <= in_mant;
        r_s1_exp  <= in_exp;
        r_s1_lzc  <= w_lzc;
      end
    end
  end

  always_comb begin
    w_frac = r_s1_mant[MANT_W-1:0];
    w_mant = '0;
    w_exp  = '0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_zero = 1'b0;
    if (r_s1_mant[MANT_W]) begin
      // exp+1 reaching all-ones (or already there) saturates to infinity.
      if (r_s1_exp >= c_exp_sat) begin
        w_exp = c_exp_max;
        w_ovf = 1'b1;
      end else begin
        w_mant = r_s1_mant[MANT_W:1];
        w_exp  = r_s1_exp + 1'b1;
      end
    end else if (w_frac == '0) begin
      w_zero = 1'b1;
    end else if (r_s1_exp == '0) begin
      w_mant = w_frac;
      w_unf  = 1'b1;
    end else if (CMP_W'(r_s1_lzc) >= CMP_W'(r_s1_exp)) begin
      w_mant = w_frac << (r_s1_exp - 1'b1);
      w_unf  = 1'b1;
    end else begin
      w_mant = w_frac << r_s1_lzc;
      w_exp  = r_s1_exp - EXP_W'(r_s1_lzc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_sign <= 1'b0;
      r_out_mant <= '0;
      r_out_exp  <= '0;
      r_out_ovf  <= 1'b0;
      r_out_unf  <= 1'b0;
      r_out_zero <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sign <= r_s1_sign;
        r_out_mant <= w_mant;
        r_out_exp  <= w_exp;
        r_out_ovf  <= w_ovf;
        r_out_unf  <= w_unf;
        r_out_zero <= w_zero;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_sign  = r_out_sign;
  assign out_mant  = r_out_mant;
  assign out_exp   = r_out_exp;
  assign out_ovf   = r_out_ovf;
  assign out_unf   = r_out_unf;
  assign out_zero  = r_out_zero;

`ifdef FP_NORM_EVENT_CNT_EN
  logic        w_out_hs;
  logic [15:0] r_ovf_cnt;
  logic [15:0] r_unf_cnt;

  assign w_out_hs = r_s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else if (cnt_clr) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_out_hs && r_out_ovf && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
      if (w_out_hs && r_out_unf && (r_unf_cnt != 16'hFFFF)) r_unf_cnt <= r_unf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign unf_cnt = r_unf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_norm_pipe.sv
`default_nettype none
// Directed testbench for fp_norm_pipe (default parameters MANT_W=24, EXP_W=8).
module tb_fp_norm_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [24:0] in_mant = '0;
  logic [7:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_ovf;
  logic        out_unf;
  logic        out_zero;
`ifdef FP_NORM_EVENT_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] ovf_cnt;
  logic [15:0] unf_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Packed result: {sign, mant[23:0], exp[7:0], ovf, unf, zero}
  logic [35:0] got;
  assign got = {out_sign, out_mant, out_exp, out_ovf, out_unf, out_zero};

  // Stream words shared by the back-to-back and back-pressure tests.
  logic [24:0] sm [4] = '{25'h0_800001, 25'h0_400000, 25'h1_000002, 25'h0_000001};
  logic [7:0]  se [4] = '{8'h10, 8'h10, 8'h10, 8'h30};
  logic [35:0] sx [4] = '{{1'b0, 24'h800001, 8'h10, 3'b000},
                          {1'b1, 24'h800000, 8'h0F, 3'b000},
                          {1'b0, 24'h800001, 8'h11, 3'b000},
                          {1'b1, 24'h800000, 8'h19, 3'b000}};

  fp_norm_pipe #(.MANT_W(24), .EXP_W(8), .LZC_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_zero(out_zero)
`ifdef FP_NORM_EVENT_CNT_EN
    , .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single word into an empty pipe; returns at the negedge two edges after acceptance.
  task automatic issue_one(input logic s, input logic [24:0] m, input logic [7:0] e);
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_mant = m; in_exp = e; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, got} !== 37'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, got});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  // Table-driven single-word cases: carry, lzc, overflow, zero, underflow.
  task automatic test_vectors(input string name, input int n, input logic [24:0] m [8],
                              input logic [7:0] e [8], input logic [35:0] x [8]);
    for (int i = 0; i < n; i++) begin
      issue_one(i[0], m[i], e[i]);
      tests_run++;
      if (out_valid !== 1'b1 || got !== {i[0], x[i][34:0]}) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got valid=%b %h expected valid=1 %h",
                 name, i, out_valid, got, {i[0], x[i][34:0]});
      end
    end
  endtask

  task automatic test_carry();
    logic [24:0] m [8] = '{25'h1_800000, 25'h1_000003, 25'h1_FFFFFF, 0, 0, 0, 0, 0};
    logic [7:0]  e [8] = '{8'h80, 8'h80, 8'h01, 0, 0, 0, 0, 0};
    logic [35:0] x [8] = '{{1'b0, 24'hC00000, 8'h81, 3'b000},
                           {1'b0, 24'h800001, 8'h81, 3'b000},
                           {1'b0, 24'hFFFFFF, 8'h02, 3'b000}, 0, 0, 0, 0, 0};
    test_vectors("carry", 3, m, e, x);
  endtask

  task automatic test_lzc();
    logic [24:0] m [8] = '{25'h0_001234, 25'h0_800000, 25'h0_000100, 25'h0_000001, 0, 0, 0, 0};
    logic [7:0]  e [8] = '{8'h80, 8'h22, 8'h10, 8'h80, 0, 0, 0, 0};
    logic [35:0] x [8] = '{{1'b0, 24'h91A000, 8'h75, 3'b000},
                           {1'b0, 24'h800000, 8'h22, 3'b000},
                           {1'b0, 24'h800000, 8'h01, 3'b000},
                           {1'b0, 24'h800000, 8'h69, 3'b000}, 0, 0, 0, 0};
    test_vectors("lzc", 4, m, e, x);
  endtask

  task automatic test_overflow();
    logic [24:0] m [8] = '{25'h1_800000, 25'h1_FFFFFF, 25'h1_000002, 0, 0, 0, 0, 0};
    logic [7:0]  e [8] = '{8'hFE, 8'hFF, 8'hFD, 0, 0, 0, 0, 0};
    logic [35:0] x [8] = '{{1'b0, 24'h000000, 8'hFF, 3'b100},
                           {1'b0, 24'h000000, 8'hFF, 3'b100},
                           {1'b0, 24'h800001, 8'hFE, 3'b000}, 0, 0, 0, 0, 0};
    test_vectors("overflow", 3, m, e, x);
  endtask

  task automatic test_zero_unf();
    logic [24:0] m [8] = '{25'h0_000000, 25'h0_000100, 25'h0_000100, 25'h0_000100,
                           25'h0_000000, 0, 0, 0};
    logic [7:0]  e [8] = '{8'h40, 8'h05, 8'h0F, 8'h00, 8'h00, 0, 0, 0};
    logic [35:0] x [8] = '{{1'b0, 24'h000000, 8'h00, 3'b001},
                           {1'b0, 24'h001000, 8'h00, 3'b010},
                           {1'b0, 24'h400000, 8'h00, 3'b010},
                           {1'b0, 24'h000100, 8'h00, 3'b010},
                           {1'b0, 24'h000000, 8'h00, 3'b001}, 0, 0, 0};
    test_vectors("zero_unf", 5, m, e, x);
  endtask

  task automatic test_back_to_back();
    int nrd = 0;
    int last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 12 && nrd < 4; c++) begin
      @(negedge clk);
      if (c < 4) begin
        in_valid = 1'b1; in_sign = c[0]; in_mant = sm[c]; in_exp = se[c];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 4) begin
        tests_run++;
        if (in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_in_ready[%0d]: got %b expected 1", c, in_ready);
        end
      end
      if (out_valid === 1'b1) begin
        tests_run++;
        if (got !== sx[nrd]) begin
          tests_failed++;
          $display("FAIL b2b_word[%0d]: got %h expected %h", nrd, got, sx[nrd]);
        end
        nrd++;
        last = c;
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (nrd != 4 || last != 5) begin
      tests_failed++;
      $display("FAIL b2b_timing: got %0d words last at cycle %0d expected 4 words last at cycle 5",
               nrd, last);
    end
  endtask

  task automatic test_backpressure();
    int nwr = 0;
    int nrd = 0;
    for (int c = 0; c < 30 && nrd < 4; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      if (nwr < 4) begin
        in_valid = 1'b1; in_sign = nwr[0]; in_mant = sm[nwr]; in_exp = se[nwr];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 2 && c <= 4) begin
        tests_run++;
        if (out_valid !== 1'b1 || got !== sx[0]) begin
          tests_failed++;
          $display("FAIL bp_hold[%0d]: got valid=%b %h expected valid=1 %h", c, out_valid, got, sx[0]);
        end
        tests_run++;
        if (in_ready !== 1'b0 || nwr != 2) begin
          tests_failed++;
          $display("FAIL bp_in_ready[%0d]: got in_ready=%b accepted=%0d expected 0 and 2",
                   c, in_ready, nwr);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        tests_run++;
        if (got !== sx[nrd]) begin
          tests_failed++;
          $display("FAIL bp_word[%0d]: got %h expected %h", nrd, got, sx[nrd]);
        end
        nrd++;
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) nwr++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (nrd != 4 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got %0d words trailing valid=%b expected 4 words valid=0", nrd, out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b1; in_mant = 25'h1_800000; in_exp = 8'hFE;
    @(negedge clk);
    in_mant = 25'h1_400000; in_exp = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, got} !== 37'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %h expected 0", {out_valid, got});
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    tests_run++;
    if (seen != 0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_flush: got %0d stray outputs in_ready=%b expected 0 and 1", seen, in_ready);
    end
  endtask

`ifdef FP_NORM_EVENT_CNT_EN
  task automatic test_counters();
    @(negedge clk); cnt_clr = 1'b1;
    @(negedge clk); cnt_clr = 1'b0;
    repeat (3) issue_one(1'b0, 25'h1_000000, 8'hFE);
    issue_one(1'b0, 25'h0_000100, 8'h05);
    @(negedge clk);
    tests_run++;
    if (ovf_cnt !== 16'd3 || unf_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL cnt_count: got ovf=%0d unf=%0d expected 3 and 1", ovf_cnt, unf_cnt);
    end
    issue_one(1'b0, 25'h1_000000, 8'hFF);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    tests_run++;
    if (ovf_cnt !== 16'd0 || unf_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL cnt_clear: got ovf=%0d unf=%0d expected 0 and 0", ovf_cnt, unf_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_carry();
    test_lzc();
    test_overflow();
    test_zero_unf();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef FP_NORM_EVENT_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Parametrised, pipelined post-add normaliser for the floating-point adder datapath.
- Accepts the raw sum, its carry bit, the exponent and the sign. Emits a normalised mantissa, the adjusted exponent and status flags.
- Sits between the mantissa adder and the result packer. Two-stage pipeline with valid/ready handshakes on both sides.
- Adds over the previous unit: configurable width, leading-zero-count normalisation, denormal/overflow/zero handling, back-pressure.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 8, biased exponent width.
- LZC_W, 5, leading-zero-count width; must satisfy 2^LZC_W > MANT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  unit can accept the input word.
- in_sign  in  1  result sign, passed through unchanged.
- in_mant  in  MANT_W+1  adder sum; the MSB is the carry-out.
- in_exp  in  EXP_W  pre-normalisation biased exponent.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_sign  out  1  sign.
- out_mant  out  MANT_W  normalised mantissa.
- out_exp  out  EXP_W  adjusted exponent.
- out_ovf  out  1  exponent overflow; result is infinity.
- out_unf  out  1  result is denormal.
- out_zero  out  1  result is exact zero.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - all stage valids, out_valid and all out_* data and flags are 0;
  - in_ready is 1 one cycle after release.
- Reset asserted mid-operation discards in-flight words; no partial output.

Stage 1 (capture):
- Register sign/mant/exp on an in_valid && in_ready handshake.
- Compute lzc = leading zeros of mant[MANT_W-1:0]; lzc = MANT_W when all zero.

Stage 2 (normalise), precedence top-down:
- carry=1:
  - mant_out = mant[MANT_W:1] (the dropped LSB is discarded);
  - exp_out = exp+1;
  - if exp+1 equals all-ones: mant_out=0, ovf=1;
  - exp input already all-ones with carry=1: ovf=1, exp_out all-ones, mant_out=0 (no wrap).
- mant[MANT_W-1:0]==0: mant_out=0, exp_out=0, zero=1.
- exp==0 (already denormal): no shift, exp_out=0, unf=1.
- lzc >= exp: shift left by exp-1, exp_out=0, unf=1.
- Otherwise: shift left by lzc, exp_out = exp-lzc; no flags.

Timing:
- Latency is exactly 2 cycles from input handshake to out_valid with no stall.
- Throughput is 1 word/cycle.

Handshake:
- adv2 = !s2_valid || out_ready.
- adv1 = adv2.
- in_ready = !s1_valid || adv1.
- out_* hold stable while out_valid && !out_ready.
- out_valid never drops without an out_ready handshake.
- Order is preserved; no word is dropped or duplicated.
- Simultaneous in and out handshakes in one cycle are both honoured (full rate).

Optional Feature:
- Macro: FP_NORM_EVENT_CNT_EN.
- When defined, three ports are added:
  - cnt_clr (in, 1);
  - ovf_cnt (out, 16);
  - unf_cnt (out, 16).
- Counter behaviour:
  - each counter increments once per output handshake carrying the matching flag;
  - counters saturate at 16'hFFFF;
  - cnt_clr=1 synchronously zeroes both and overrides an increment in the same cycle;
  - both reset to 0 asynchronously.
- When not defined: the ports and counters are absent; the datapath is identical.

Test Plan:
- Carry, MANT_W=24, EXP_W=8: mant=25'h1_800000, exp=8'h80, out_ready=1 -> two cycles later out_mant=24'hC00000, out_exp=8'h81, flags 0.
- LZC shift: mant=25'h0_001234, exp=8'h80 -> lzc=11, out_mant=24'h91A000, out_exp=8'h75.
- Overflow: carry with exp=8'hFE -> out_exp=8'hFF, out_mant=0, out_ovf=1.
- Zero and underflow:
  - mant=0, exp=8'h40 -> out_zero=1, mant/exp 0;
  - mant=25'h0_000100, exp=8'h05 -> out_mant=24'h001000, out_exp=0, out_unf=1.
- Back-pressure: issue 4 back-to-back words with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted, out_* stable; on out_ready=1 all 4 emerge in order, none lost.
- Reset: rst_n pulsed low with 2 words in flight -> out_valid=0 immediately, nothing emitted afterward. With FP_NORM_EVENT_CNT_EN: 3 overflow results -> ovf_cnt=3; cnt_clr -> 0.
